// File: rtl/lfsr_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR period monitor:
//   LFSR_W      default LFSR state width
//   MON_CNT_W   default period counter width (must be >= LFSR_W + 1)
//   mon_state_t monitor FSM state encoding
// ---------------------------------------------------------------------------
package lfsr_pkg;

  localparam int LFSR_W    = 64;
  localparam int MON_CNT_W = 65;

  typedef enum logic [1:0] {
    MON_IDLE    = 2'd0,
    MON_CAPTURE = 2'd1,
    MON_RUN     = 2'd2,
    MON_DONE    = 2'd3
  } mon_state_t;

endpackage

// File: rtl/lfsr_period_monitor_mon_counter.sv
// ---------------------------------------------------------------------------
// mon_counter
// Advance counter for the period monitor. Holds the number of advances seen
// since the origin was captured and presents the would-be next value so the
// FSM can decide termination before the count is committed.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear        force count to zero
//   enable       commit next into count
//   limit        timeout threshold, 0 disables the limit compare
//   next         count + 1
//   hit_limit    limit is non-zero and next equals it
//   sat          next is all-ones (count may not advance further)
// ---------------------------------------------------------------------------
module mon_counter
  import lfsr_pkg::*;
#(
  parameter int CNT_W = MON_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] next,
  output logic             hit_limit,
  output logic             sat
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= next;
    end
  end

  assign next      = count + CNT_W'(1);
  assign hit_limit = (limit != '0) && (next == limit);
  // The FSM stops on saturation, so count itself never wraps.
  assign sat       = &next;

endmodule

// File: rtl/lfsr_period_monitor.sv
// ---------------------------------------------------------------------------
// lfsr_period_monitor
// Measures the period of an LFSR state stream. The first valid state after
// start is latched as the origin; valid advances are counted until the origin
// recurs, the limit/saturation is reached, or the origin is the all-zero
// lock-up state. All outputs are registered.
// Optional feature macro: LFSR_MON_MAXCHK_EN -- when defined, 'maximal' flags
// a found period of 2^WIDTH-1; when undefined, 'maximal' is tied low.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   start         begin or restart a measurement (aborts a running one)
//   state_valid   state_in carries a new LFSR state this cycle
//   state_in      LFSR state
//   limit         timeout in advances, 0 = run to counter saturation
//   busy          high in CAPTURE and RUN
//   done          one-cycle pulse when a measurement ends
//   found         origin recurred (held)
//   timeout       limit or saturation reached first (held)
//   zero_lock     origin was all-zero (held)
//   period        advances from origin to recurrence / termination (held)
//   maximal       found maximal-length period (feature macro only)
// ---------------------------------------------------------------------------
module lfsr_period_monitor
  import lfsr_pkg::*;
#(
  parameter int WIDTH = LFSR_W,
  parameter int CNT_W = MON_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             state_valid,
  input  logic [WIDTH-1:0] state_in,
  input  logic [CNT_W-1:0] limit,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             timeout,
  output logic             zero_lock,
  output logic [CNT_W-1:0] period,
  output logic             maximal
);

  mon_state_t       state, state_n;
  logic [WIDTH-1:0] origin, origin_n;
  logic             done_n, found_n, timeout_n, zero_lock_n;
  logic [CNT_W-1:0] period_n;
  logic             cnt_clr, cnt_en, clear_flags;
  logic [CNT_W-1:0] cnt_next;
  logic             cnt_hit_limit, cnt_sat;

  mon_counter #(.CNT_W(CNT_W)) u_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clr),
    .enable    (cnt_en),
    .limit     (limit),
    .next      (cnt_next),
    .hit_limit (cnt_hit_limit),
    .sat       (cnt_sat)
  );

  always_comb begin
    state_n     = state;
    origin_n    = origin;
    done_n      = 1'b0;
    found_n     = found;
    timeout_n   = timeout;
    zero_lock_n = zero_lock;
    period_n    = period;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    clear_flags = 1'b0;
    // start is honoured in every state; in CAPTURE/RUN it aborts silently.
    if (start) begin
      state_n     = MON_CAPTURE;
      clear_flags = 1'b1;
      found_n     = 1'b0;
      timeout_n   = 1'b0;
      zero_lock_n = 1'b0;
      period_n    = '0;
      cnt_clr     = 1'b1;
    end else begin
      case (state)
        MON_CAPTURE: begin
          if (state_valid) begin
            origin_n = state_in;
            cnt_clr  = 1'b1;
            if (state_in == '0) begin
              // All-zero state never leaves itself: report a period of 1.
              zero_lock_n = 1'b1;
              found_n     = 1'b1;
              period_n    = CNT_W'(1);
              done_n      = 1'b1;
              state_n     = MON_DONE;
            end else begin
              state_n = MON_RUN;
            end
          end
        end
        MON_RUN: begin
          if (state_valid) begin
            // Recurrence is checked first so it wins over a same-advance timeout.
            if (state_in == origin) begin
              found_n  = 1'b1;
              period_n = cnt_next;
              done_n   = 1'b1;
              state_n  = MON_DONE;
            end else if (cnt_hit_limit || cnt_sat) begin
              timeout_n = 1'b1;
              period_n  = cnt_next;
              done_n    = 1'b1;
              state_n   = MON_DONE;
            end else begin
              cnt_en = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= MON_IDLE;
      origin    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      timeout   <= 1'b0;
      zero_lock <= 1'b0;
      period    <= '0;
    end else begin
      state     <= state_n;
      origin    <= origin_n;
      busy      <= (state_n == MON_CAPTURE) || (state_n == MON_RUN);
      done      <= done_n;
      found     <= found_n;
      timeout   <= timeout_n;
      zero_lock <= zero_lock_n;
      period    <= period_n;
    end
  end

`ifdef LFSR_MON_MAXCHK_EN
  localparam logic [CNT_W-1:0] FULL_PERIOD = {{(CNT_W-WIDTH){1'b0}}, {WIDTH{1'b1}}};

  logic maximal_r, maximal_n;

  always_comb begin
    maximal_n = maximal_r;
    if (clear_flags) begin
      maximal_n = 1'b0;
    end else if (done_n) begin
      maximal_n = found_n && !zero_lock_n && (period_n == FULL_PERIOD);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      maximal_r <= 1'b0;
    end else begin
      maximal_r <= maximal_n;
    end
  end

  assign maximal = maximal_r;
`else
  assign maximal = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// ---------------------------------------------------------------------------
// tb_lfsr_period_monitor
// Scoreboard bench for lfsr_period_monitor at WIDTH=4, CNT_W=5. Each started
// measurement pushes its expected result and the cycle at which 'done' must
// appear; a monitor pops and compares on every 'done' pulse.
// ---------------------------------------------------------------------------
module tb_lfsr_period_monitor;

  logic       clk;
  logic       reset;
  logic       start;
  logic       state_valid;
  logic [3:0] state_in;
  logic [4:0] limit;
  logic       busy, done, found, timeout, zero_lock, maximal;
  logic [4:0] period;

  lfsr_period_monitor #(.WIDTH(4), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .state_valid (state_valid),
    .state_in    (state_in),
    .limit       (limit),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .timeout     (timeout),
    .zero_lock   (zero_lock),
    .period      (period),
    .maximal     (maximal)
  );

`ifdef LFSR_MON_MAXCHK_EN
  localparam logic MAX_EXP = 1'b1;
`else
  localparam logic MAX_EXP = 1'b0;
`endif

  typedef struct {
    logic       found;
    logic       timeout;
    logic       zero_lock;
    logic       maximal;
    logic [4:0] period;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_done = 1'b0;

  // x^4+x^3+1 from 0x1, and a short 5-state loop.
  logic [3:0] max_tbl [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                               4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  logic [3:0] five_tbl [5] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (done) begin
      chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done seen with no measurement pending (cycle %0d)", cyc);
      end else begin
        got = sb.pop_front();
        chk("found",     {31'd0, found},     {31'd0, got.found});
        chk("timeout",   {31'd0, timeout},   {31'd0, got.timeout});
        chk("zero_lock", {31'd0, zero_lock}, {31'd0, got.zero_lock});
        chk("maximal",   {31'd0, maximal},   {31'd0, got.maximal});
        chk("period",    {27'd0, period},    {27'd0, got.period});
        chk("done_cycle", cyc, got.cyc);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
    prev_done = done;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // sel: 0 = maximal sequence, 1 = 5-state loop, 2 = all-zero
  task automatic feed(input int sel, input int n, input int stride);
    for (int i = 0; i < n; i++) begin
      state_valid = 1'b1;
      case (sel)
        0:       state_in = max_tbl[i % 15];
        1:       state_in = five_tbl[i % 5];
        default: state_in = 4'h0;
      endcase
      tick();
      if (stride == 2) begin
        state_valid = 1'b0;
        state_in    = 4'($urandom);
        tick();
      end
    end
    state_valid = 1'b0;
  endtask

  task automatic measure(input int sel, input int n, input int stride, input logic [4:0] lim,
                         input logic f, input logic t, input logic z, input logic m,
                         input logic [4:0] p);
    exp_t e;
    e.found = f; e.timeout = t; e.zero_lock = z; e.maximal = m; e.period = p;
    // start edge is next, capture edge after it, then (n-1) strides to the end
    e.cyc = cyc + 2 + (n - 1) * stride;
    sb.push_back(e);
    limit = lim;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(sel, n, stride);
    repeat (3) tick();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_done"},      {31'd0, done},      32'd0);
    chk({tag, "_found"},     {31'd0, found},     32'd0);
    chk({tag, "_timeout"},   {31'd0, timeout},   32'd0);
    chk({tag, "_zero_lock"}, {31'd0, zero_lock}, 32'd0);
    chk({tag, "_maximal"},   {31'd0, maximal},   32'd0);
    chk({tag, "_period"},    {27'd0, period},    32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    state_valid = 1'b0;
    state_in    = 4'h0;
    limit       = 5'd0;
    repeat (2) tick();
    chk_reset_state("reset");
    reset = 1'b0;
    tick();

    // Maximal-length run, then verify results are held in DONE
    measure(0, 16, 1, 5'd0, 1'b1, 1'b0, 1'b0, MAX_EXP, 5'd15);
    chk("hold_found",  {31'd0, found},  32'd1);
    chk("hold_period", {27'd0, period}, 32'd15);
    chk("hold_done",   {31'd0, done},   32'd0);

    // 5-state loop
    measure(1, 6, 1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5);
    // All-zero origin: done right after capture
    measure(2, 1, 1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1);
    // Limit reached before recurrence
    measure(0, 7, 1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 5'd6);
    // Limit and recurrence on the same advance: recurrence wins
    measure(0, 16, 1, 5'd15, 1'b1, 1'b0, 1'b0, MAX_EXP, 5'd15);
    // Valid every other cycle, junk on idle cycles
    measure(0, 16, 2, 5'd0, 1'b1, 1'b0, 1'b0, MAX_EXP, 5'd15);

    // Abort at count 7, restart, then reset (together with start) at count 3
    limit = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(0, 8, 1);
    chk("busy_in_run", {31'd0, busy}, 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_found_clr",  {31'd0, found},  32'd0);
    chk("restart_period_clr", {27'd0, period}, 32'd0);
    feed(0, 4, 1);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk_reset_state("midrun_reset");
    repeat (3) tick();
    chk("idle_after_reset_busy", {31'd0, busy}, 32'd0);

    // Every pending expectation must have been consumed
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d measurements never completed, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
